abp_sender: RTL

Alternating-bit-protocol packet sender, the transmit-side counterpart of the ABP receiver. It buffers one payload packet from an upstream AXI Stream source, frames it with a one-beat header carrying the sequence bit, and transmits it downstream. It then waits for an acknowledgement carrying the same bit, retransmitting on timeout up to a retry limit. Only one packet is in flight at a time.

---
 rtl/abp_sender.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/abp_sender.sv
// Alternating-bit-protocol transmitter: buffers one AXI Stream packet, frames it
// with a sequence-bit header, and retransmits on ack timeout up to a retry limit.
module abp_sender #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 7
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  ack_valid,
  input  logic                  ack_seq,
  output logic                  pkt_done,
  output logic                  pkt_dropped,
  output logic                  overflow
);

  localparam int unsigned PTR_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] SEND_HDR  = 2'd1;
  localparam logic [1:0] SEND_DATA = 2'd2;
  localparam logic [1:0] WAIT_ACK  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  seq_q, seq_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      len_q, len_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [RTY_W-1:0]      retry_q, retry_d;
  logic                  ack_pend_q, ack_pend_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  pkt_dropped_q, pkt_dropped_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_LEN];

  logic ack_match;
  logic last_beat;
  logic wr_room;

  assign ack_match = ack_valid && (ack_seq == seq_q);
  assign last_beat = (rd_ptr_q == len_q - PTR_W'(1));
  assign wr_room   = (wr_ptr_q != PTR_MAX);

  always_comb begin
    s_axis_tready = (state_q == FILL);
    m_axis_tvalid = (state_q == SEND_HDR) || (state_q == SEND_DATA);
    m_axis_tlast  = (state_q == SEND_DATA) && last_beat;
    m_axis_tdata  = '0;
    if (state_q == SEND_HDR) begin
      m_axis_tdata = DATA_WIDTH'(seq_q);
    end else if (state_q == SEND_DATA) begin
      m_axis_tdata = mem_q[rd_ptr_q[IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    len_d         = len_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    ack_pend_d    = ack_pend_q;
    pkt_done_d    = 1'b0;
    pkt_dropped_d = 1'b0;
    overflow_d    = overflow_q;

    case (state_q)
      FILL: begin
        if (s_axis_tvalid) begin
          if (wr_room) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (s_axis_tlast) begin
            len_d      = wr_room ? (wr_ptr_q + PTR_W'(1)) : PTR_MAX;
            retry_d    = '0;
            ack_pend_d = 1'b0;
            state_d    = SEND_HDR;
          end
        end
      end
      SEND_HDR: begin
        if (ack_match) ack_pend_d = 1'b1;
        if (m_axis_tready) begin
          rd_ptr_d = '0;
          state_d  = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (ack_match) ack_pend_d = 1'b1;
        if (m_axis_tready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (last_beat) begin
            timer_d = '0;
            state_d = WAIT_ACK;
          end
        end
      end
      default: begin
        if (timer_q != TMR_LAST) timer_d = timer_q + TMR_W'(1);
        // An ack (live or pending) takes priority over a simultaneous timeout.
        if (ack_match || ack_pend_q) begin
          seq_d      = ~seq_q;
          pkt_done_d = 1'b1;
          wr_ptr_d   = '0;
          ack_pend_d = 1'b0;
          state_d    = FILL;
        end else if (timer_q == TMR_LAST) begin
          ack_pend_d = 1'b0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = SEND_HDR;
          end else begin
            pkt_dropped_d = 1'b1;
            wr_ptr_d      = '0;
            state_d       = FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= FILL;
      seq_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      len_q         <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
      ack_pend_q    <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_dropped_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      len_q         <= len_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      ack_pend_q    <= ack_pend_d;
      pkt_done_q    <= pkt_done_d;
      pkt_dropped_q <= pkt_dropped_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge aclk) begin
    if ((state_q == FILL) && s_axis_tvalid && wr_room) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= s_axis_tdata;
    end
  end

  assign pkt_done    = pkt_done_q;
  assign pkt_dropped = pkt_dropped_q;
  assign overflow    = overflow_q;

endmodule
